git_session_rx: RTL and testbench

GIT_SESSION_RX -- requirements
Module: git_session_rx

---
 rtl/git_session_pkg.sv | 12 +
 rtl/git_session_fifo.sv | 52 +++++
 rtl/git_session_rx.sv | 84 ++++++++
 tb/tb_git_session_rx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/git_session_pkg.sv
// Shared defaults and types for the session receive path.
// Holds word/depth defaults, statistics counter width and the decoded mode enum.
package git_session_pkg;
  localparam int DEFAULT_WIDTH = 45;
  localparam int DEFAULT_DEPTH = 4;
  localparam int CNT_W         = 16;

  typedef enum logic {
    PASS = 1'b0,
    REPL = 1'b1
  } mode_t;
endpackage

// File: rtl/git_session_fifo.sv
// Power-of-two circular buffer for received session words.
// Push is ignored when full and pop is ignored when empty.
module git_session_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 45
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [PW:0]      r_count;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign full    = (r_count == FULL_CNT);
  assign empty   = (r_count == '0);
  assign w_push  = push & ~full;
  assign w_pop   = pop & ~empty;
  assign rd_data = r_mem[r_rdPtr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= wr_data;
  end
endmodule

// File: rtl/git_session_rx.sv
// Session receiver: buffers incoming words, decodes the head as REPL/PASS
// and keeps saturating delivery statistics.
module git_session_rx
  import git_session_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] learning_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic             out_flag,
  output logic [WIDTH-1:0] session_out,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] repl_cnt,
  output logic [CNT_W-1:0] pass_cnt
);
  logic             r_resetDone;
  logic [CNT_W-1:0] r_replCnt;
  logic [CNT_W-1:0] r_passCnt;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_head;
  logic             w_push;
  logic             w_pop;
  logic             w_lowSame;
  mode_t            w_mode;

  git_session_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (w_push),
    .wr_data(learning_in),
    .pop    (w_pop),
    .rd_data(w_head),
    .full   (w_full),
    .empty  (w_empty)
  );

  // Keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_resetDone <= 1'b0;
    else        r_resetDone <= 1'b1;
  end

  assign in_ready  = r_resetDone & ~w_full;
  assign out_valid = ~w_empty;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  assign w_lowSame   = (&w_head[WIDTH-2:0]) | ~(|w_head[WIDTH-2:0]);
  assign w_mode      = (~w_head[WIDTH-1] & w_lowSame) ? REPL : PASS;
  assign out_mode    = out_valid & (w_mode == REPL);
  assign out_flag    = out_valid & (w_mode == REPL) & w_head[0];
  assign session_out = out_valid ? w_head : '0;

  // Clear wins over a coincident delivery; counts stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_replCnt <= '0;
      r_passCnt <= '0;
    end else if (clr_stats) begin
      r_replCnt <= '0;
      r_passCnt <= '0;
    end else if (w_pop) begin
      if (w_mode == REPL) begin
        if (r_replCnt != '1) r_replCnt <= r_replCnt + 1'b1;
      end else begin
        if (r_passCnt != '1) r_passCnt <= r_passCnt + 1'b1;
      end
    end
  end

  assign repl_cnt = r_replCnt;
  assign pass_cnt = r_passCnt;
endmodule

// File: tb/tb_git_session_rx.sv
// Directed self-checking bench for git_session_rx with default parameters.
module tb_git_session_rx;
  localparam int WIDTH = 45;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] learning_in;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             out_mode;
  logic             out_flag;
  logic [WIDTH-1:0] session_out;
  logic             clr_stats;
  logic [15:0]      repl_cnt;
  logic [15:0]      pass_cnt;

  int checks;
  int failures;
  int expRepl;
  int expPass;

  git_session_rx #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .learning_in(learning_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_mode   (out_mode),
    .out_flag   (out_flag),
    .session_out(session_out),
    .clr_stats  (clr_stats),
    .repl_cnt   (repl_cnt),
    .pass_cnt   (pass_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_stats = 1'b0; learning_in = '0;
    #7;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (session_out !== '0 || out_mode !== 1'b0 || out_flag !== 1'b0) begin failures++; $display("[TB] FAIL rst_fields got=%h/%b/%b exp=0/0/0", session_out, out_mode, out_flag); end
    checks++; if (repl_cnt !== 16'h0 || pass_cnt !== 16'h0) begin failures++; $display("[TB] FAIL rst_cnts got=%h/%h exp=0/0", repl_cnt, pass_cnt); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL rel_ready_early got=%b exp=0", in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rel_ready got=%b exp=1", in_ready); end
    expRepl = 0; expPass = 0;
  endtask

  task automatic test_repl();
    learning_in = 45'h0FFF_FFFF_FFFF; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_mode !== 1'b1 || out_flag !== 1'b1) begin failures++; $display("[TB] FAIL repl_decode got=%b/%b/%b exp=1/1/1", out_valid, out_mode, out_flag); end
    @(negedge clk);
    out_ready = 1'b0;
    expRepl++;
    checks++; if (repl_cnt !== 16'(expRepl)) begin failures++; $display("[TB] FAIL repl_cnt got=%0d exp=%0d", repl_cnt, expRepl); end
    checks++; if (out_valid !== 1'b0 || out_mode !== 1'b0 || out_flag !== 1'b0 || session_out !== '0) begin failures++; $display("[TB] FAIL idle_fields got=%b/%b/%b/%h exp=0", out_valid, out_mode, out_flag, session_out); end
  endtask

  task automatic test_pass();
    out_ready = 1'b0;
    learning_in = 45'h1FFF_FFFF_FFFF; in_valid = 1'b1;
    @(negedge clk);
    learning_in = 45'h0000_0000_0005;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (session_out !== 45'h1FFF_FFFF_FFFF || out_mode !== 1'b0 || out_flag !== 1'b0) begin failures++; $display("[TB] FAIL pass_first got=%h/%b/%b exp=1fffffffffff/0/0", session_out, out_mode, out_flag); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (session_out !== 45'h0000_0000_0005 || out_mode !== 1'b0) begin failures++; $display("[TB] FAIL pass_second got=%h/%b exp=5/0", session_out, out_mode); end
    @(negedge clk);
    out_ready = 1'b0;
    expPass += 2;
    checks++; if (pass_cnt !== 16'(expPass) || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL pass_cnt got=%0d/%b exp=%0d/0", pass_cnt, out_valid, expPass); end
  endtask

  task automatic test_decode();
    logic [WIDTH-1:0] words [4];
    logic             modes [4];
    logic             flags [4];
    words[0] = 45'h0000_0000_0000; modes[0] = 1'b1; flags[0] = 1'b0;
    words[1] = 45'h0FFF_FFFF_FFFE; modes[1] = 1'b0; flags[1] = 1'b0;
    words[2] = 45'h1000_0000_0000; modes[2] = 1'b0; flags[2] = 1'b0;
    words[3] = 45'h0000_0000_0001; modes[3] = 1'b0; flags[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      learning_in = words[i]; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_mode !== modes[i] || out_flag !== flags[i] || session_out !== words[i]) begin failures++; $display("[TB] FAIL decode_%0d got=%b/%b/%b/%h exp=1/%b/%b/%h", i, out_valid, out_mode, out_flag, session_out, modes[i], flags[i], words[i]); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      if (modes[i]) expRepl++; else expPass++;
      checks++; if (repl_cnt !== 16'(expRepl) || pass_cnt !== 16'(expPass)) begin failures++; $display("[TB] FAIL decode_cnt_%0d got=%0d/%0d exp=%0d/%0d", i, repl_cnt, pass_cnt, expRepl, expPass); end
    end
  endtask

  task automatic test_full();
    logic [WIDTH-1:0] words [5];
    for (int i = 0; i < 5; i++) words[i] = 45'h1000_0000_0010 + 45'(i);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      learning_in = words[i]; in_valid = 1'b1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL fill_ready_%0d got=%b exp=1", i, in_ready); end
      @(negedge clk);
    end
    learning_in = words[4];
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || session_out !== words[0]) begin failures++; $display("[TB] FAIL full_hold got=%b/%h exp=0/%h", in_ready, session_out, words[0]); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || session_out !== words[1]) begin failures++; $display("[TB] FAIL resume got=%b/%h exp=1/%h", in_ready, session_out, words[1]); end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 2; k < 5; k++) begin
      checks++; if (out_valid !== 1'b1 || session_out !== words[k]) begin failures++; $display("[TB] FAIL drain_%0d got=%b/%h exp=1/%h", k, out_valid, session_out, words[k]); end
      @(negedge clk);
    end
    out_ready = 1'b0;
    expPass += 5;
    checks++; if (out_valid !== 1'b0 || pass_cnt !== 16'(expPass)) begin failures++; $display("[TB] FAIL full_done got=%b/%0d exp=0/%0d", out_valid, pass_cnt, expPass); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      learning_in = 45'h1ABC_0000_0000 + 45'(i); in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_pre got=%b exp=1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || pass_cnt !== 16'h0 || repl_cnt !== 16'h0) begin failures++; $display("[TB] FAIL mid_async got=%b/%b/%0d/%0d exp=0/0/0/0", out_valid, in_ready, pass_cnt, repl_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_after got=%b/%b exp=0/1", out_valid, in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || session_out !== '0) begin failures++; $display("[TB] FAIL mid_stale got=%b/%h exp=0/0", out_valid, session_out); end
    learning_in = 45'h1234_5678_9ABC; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (session_out !== 45'h1234_5678_9ABC) begin failures++; $display("[TB] FAIL mid_fresh got=%h exp=123456789abc", session_out); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || pass_cnt !== 16'd1) begin failures++; $display("[TB] FAIL mid_empty got=%b/%0d exp=0/1", out_valid, pass_cnt); end
  endtask

  task automatic test_saturate();
    int pushes;
    int cyc;
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    checks++; if (repl_cnt !== 16'h0 || pass_cnt !== 16'h0) begin failures++; $display("[TB] FAIL clr_idle got=%0d/%0d exp=0/0", repl_cnt, pass_cnt); end
    learning_in = '0; out_ready = 1'b1; in_valid = 1'b1;
    pushes = 0; cyc = 0;
    while (pushes < 65535 && cyc < 70000) begin
      if (in_ready) pushes++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    checks++; if (pushes != 65535 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL sat_stream got=%0d/%b exp=65535/0", pushes, out_valid); end
    checks++; if (repl_cnt !== 16'hFFFF || pass_cnt !== 16'h0) begin failures++; $display("[TB] FAIL sat_reach got=%h/%h exp=ffff/0", repl_cnt, pass_cnt); end
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (repl_cnt !== 16'hFFFF) begin failures++; $display("[TB] FAIL sat_hold got=%h exp=ffff", repl_cnt); end
    out_ready = 1'b0;
    learning_in = 45'h1555_0000_0000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1; clr_stats = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; clr_stats = 1'b0;
    checks++; if (repl_cnt !== 16'h0 || pass_cnt !== 16'h0 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL clr_hs got=%h/%h/%b exp=0/0/0", repl_cnt, pass_cnt, out_valid); end
  endtask

  initial begin
    checks = 0; failures = 0; expRepl = 0; expPass = 0;
    test_reset();
    test_repl();
    test_pass();
    test_decode();
    test_full();
    test_reset_midstream();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
